// File: rtl/multicycle_sequencer_if.sv
// Sequencer <-> datapath/memory control bundle for the multi-cycle RV32I core.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_sequencer_if;
  logic [6:0]  op;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        addr_src;
  logic        ir_en;
  logic        pc_en;
  logic [1:0]  pc_src;
  logic        reg_we;
  logic [1:0]  result_src;
  logic        retire;
  logic [31:0] instret;
  logic        halted;
  logic [1:0]  trap_cause;

  modport master (
    input  op, br_taken, mem_ready,
    output mem_req, mem_we, addr_src, ir_en, pc_en, pc_src, reg_we,
           result_src, retire, instret, halted, trap_cause
  );

  modport slave (
    output op, br_taken, mem_ready,
    input  mem_req, mem_we, addr_src, ir_en, pc_en, pc_src, reg_we,
           result_src, retire, instret, halted, trap_cause
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with shared memory port.
// Optional memory-wait timeout trap enabled by defining SEQ_TIMEOUT_EN.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;

  state_t      state_q, state_d;
  logic [6:0]  op_q;
  logic [31:0] instret_q;
  logic [1:0]  trap_cause_q;
  logic        timeout;
  logic        legal;

  logic       mem_req, mem_we, addr_src, ir_en, pc_en, reg_we, retire, halted;
  logic [1:0] pc_src, result_src;

`ifdef SEQ_TIMEOUT_EN
  logic [15:0] wait_q;

  // Anything other than a stalled FETCH/MEM cycle clears the count, which covers entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else if ((state_q == FETCH || state_q == MEM) && !bus.mem_ready) begin
      wait_q <= wait_q + 16'd1;
    end else begin
      wait_q <= '0;
    end
  end

  assign timeout = (wait_q == TIMEOUT_CYCLES[15:0]) && !bus.mem_ready;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    unique case (bus.op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    reg_we     = 1'b0;
    result_src = 2'b00;
    retire     = 1'b0;
    halted     = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_en   = 1'b1;
          state_d = DECODE;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      DECODE: state_d = legal ? EXEC : TRAP;
      EXEC: begin
        if (op_q == OP_LOAD || op_q == OP_STORE) begin
          state_d = MEM;
        end else if (op_q == OP_BR) begin
          pc_en   = 1'b1;
          pc_src  = bus.br_taken ? 2'b01 : 2'b00;
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
        mem_we   = (op_q == OP_STORE);
        if (bus.mem_ready) begin
          if (op_q == OP_STORE) begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      WB: begin
        reg_we  = 1'b1;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
        if (op_q == OP_LOAD)                        result_src = 2'b01;
        else if (op_q == OP_JAL || op_q == OP_JALR) result_src = 2'b10;
        if (op_q == OP_JAL)       pc_src = 2'b01;
        else if (op_q == OP_JALR) pc_src = 2'b10;
      end
      TRAP: halted = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      instret_q    <= '0;
      trap_cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= bus.op;
      if (retire) instret_q <= instret_q + 32'd1;
      // Only DECODE traps on opcode; FETCH/MEM can only trap on timeout.
      if (state_q != TRAP && state_d == TRAP)
        trap_cause_q <= (state_q == DECODE) ? 2'b01 : 2'b10;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.addr_src   = addr_src;
  assign bus.ir_en      = ir_en;
  assign bus.pc_en      = pc_en;
  assign bus.pc_src     = pc_src;
  assign bus.reg_we     = reg_we;
  assign bus.result_src = result_src;
  assign bus.retire     = retire;
  assign bus.halted     = halted;
  assign bus.instret    = instret_q;
  assign bus.trap_cause = trap_cause_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed, table-driven bench for multicycle_sequencer plus hand-written corner sequences.
module tb_multicycle_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_sequencer_if bus();

  multicycle_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [6:0]  op;
    logic        br;
    int unsigned fstall;
    int unsigned mstall;
    int unsigned cyc;
    int unsigned req;
    int unsigned we;
    int unsigned rwe;
    logic [1:0]  rs;
    logic [1:0]  ps;
  } vec_t;

  vec_t        vecs[14];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] model_instret = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench at a negedge with the DUT in FETCH.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_trap_cause", bus.trap_cause, 0);
    check("rst_instret", bus.instret, 0);
    check("rst_strobes", {bus.ir_en, bus.pc_en, bus.reg_we, bus.retire, bus.mem_we}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_state_idle", 32'(dut.state_q), 0);
    @(negedge clk);
    check("rst_fetch_req", bus.mem_req, 1);
    model_instret = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int unsigned cyc = 0, req = 0, we = 0, ir = 0, rwe = 0, pce = 0, bad = 0;
    int unsigned fs = v.fstall, ms = v.mstall;
    logic done = 1'b0;
    logic [1:0] rs = 2'b00, ps = 2'b00;
    string tag;
    tag = $sformatf("v%0d_op%02h", idx, v.op);
    bus.op = v.op;
    bus.br_taken = v.br;
    while (!done && cyc < 30) begin
      if (bus.mem_req && bus.addr_src && ms > 0) begin
        bus.mem_ready = 1'b0; ms--;
      end else if (bus.mem_req && !bus.addr_src && fs > 0) begin
        bus.mem_ready = 1'b0; fs--;
      end else begin
        bus.mem_ready = 1'b1;
      end
      #1;
      cyc++;
      if (bus.mem_req) req++;
      if (bus.mem_we)  we++;
      if (bus.ir_en)   ir++;
      if (bus.reg_we)  rwe++;
      if (bus.pc_en)   pce++;
      if (!bus.mem_ready && (bus.ir_en || bus.retire || bus.pc_en)) bad++;
      if (bus.retire) begin
        done = 1'b1;
        rs = bus.result_src;
        ps = bus.pc_src;
      end
      @(negedge clk);
    end
    model_instret = model_instret + 32'd1;
    check({tag, "_retired"}, done, 1);
    check({tag, "_cycles"}, cyc, v.cyc);
    check({tag, "_req_cycles"}, req, v.req);
    check({tag, "_we_cycles"}, we, v.we);
    check({tag, "_ir_en_once"}, ir, 1);
    check({tag, "_reg_we"}, rwe, v.rwe);
    check({tag, "_pc_en_once"}, pce, 1);
    check({tag, "_stall_strobes"}, bad, 0);
    check({tag, "_result_src"}, rs, v.rs);
    check({tag, "_pc_src"}, ps, v.ps);
    check({tag, "_instret"}, bus.instret, model_instret);
  endtask

  initial begin
    int unsigned cnt;
    //          op     br  fs ms cyc req we rwe rs     ps
    vecs[0]  = '{7'h33, 0, 0, 0, 4, 1, 0, 1, 2'b00, 2'b00};
    vecs[1]  = '{7'h13, 0, 0, 0, 4, 1, 0, 1, 2'b00, 2'b00};
    vecs[2]  = '{7'h37, 0, 0, 0, 4, 1, 0, 1, 2'b00, 2'b00};
    vecs[3]  = '{7'h17, 0, 0, 0, 4, 1, 0, 1, 2'b00, 2'b00};
    vecs[4]  = '{7'h6F, 0, 0, 0, 4, 1, 0, 1, 2'b10, 2'b01};
    vecs[5]  = '{7'h67, 0, 0, 0, 4, 1, 0, 1, 2'b10, 2'b10};
    vecs[6]  = '{7'h03, 0, 0, 0, 5, 2, 0, 1, 2'b01, 2'b00};
    vecs[7]  = '{7'h03, 0, 0, 3, 8, 5, 0, 1, 2'b01, 2'b00};
    vecs[8]  = '{7'h23, 0, 0, 0, 4, 2, 1, 0, 2'b00, 2'b00};
    vecs[9]  = '{7'h23, 0, 0, 1, 5, 3, 2, 0, 2'b00, 2'b00};
    vecs[10] = '{7'h63, 1, 0, 0, 3, 1, 0, 0, 2'b00, 2'b01};
    vecs[11] = '{7'h63, 0, 0, 0, 3, 1, 0, 0, 2'b00, 2'b00};
    vecs[12] = '{7'h33, 0, 2, 0, 6, 3, 0, 1, 2'b00, 2'b00};
    vecs[13] = '{7'h63, 1, 1, 0, 4, 2, 0, 0, 2'b00, 2'b01};

    bus.op = 7'h33;
    bus.br_taken = 1'b0;
    bus.mem_ready = 1'b1;

    do_reset();
    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // instret wrap: preload all-ones, retire one store
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    model_instret = 32'hFFFF_FFFF;
    run_vec(100, vecs[8]);

    // Reset asserted mid-MEM on a stalled store
    bus.op = 7'h23;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("midmem_req", bus.mem_req, 1);
    check("midmem_addr_src", bus.addr_src, 1);
    check("midmem_we", bus.mem_we, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midmem_req_async_drop", bus.mem_req, 0);
    check("midmem_no_writes", {bus.pc_en, bus.reg_we, bus.retire}, 0);
    check("midmem_instret", bus.instret, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    check("midmem_state_idle", 32'(dut.state_q), 0);
    @(negedge clk);
    check("midmem_refetch", {bus.mem_req, bus.addr_src}, 2'b10);
    model_instret = '0;

    // Illegal opcode -> sticky TRAP
    bus.op = 7'h7F;
    @(negedge clk);
    @(negedge clk);
    check("trap_halted", bus.halted, 1);
    check("trap_cause_illegal", bus.trap_cause, 2'b01);
    check("trap_state", 32'(dut.state_q), 6);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.mem_req || bus.ir_en || bus.pc_en || bus.reg_we || bus.retire || !bus.halted) cnt++;
      @(negedge clk);
    end
    check("trap_sticky_quiet", cnt, 0);
    bus.op = 7'h33;
    do_reset();

`ifdef SEQ_TIMEOUT_EN
    // Fetch never completes: 5 wait cycles (count 0..4) then TRAP
    bus.mem_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.mem_req) cnt++;
      @(negedge clk);
    end
    check("tmo_req_held", cnt, 5);
    check("tmo_halted", bus.halted, 1);
    check("tmo_cause", bus.trap_cause, 2'b10);
    do_reset();
    // mem_ready arrives on the threshold cycle and wins
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    check("tmo_race_ir_en", bus.ir_en, 1);
    @(negedge clk);
    check("tmo_race_decode", 32'(dut.state_q), 2);
    check("tmo_race_not_halted", {bus.halted, bus.trap_cause}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RV32I single-core CPU. Steps the shared datapath through fetch, decode, execute, memory and write-back for each instruction. Drives the enables and mux selects that the combinational decoder does not time: PC/IR enables, memory request, register write strobe, PC and result selects. Handshakes with a single shared instruction/data memory port and counts retired instructions.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum wait cycles for `mem_ready` before a timeout trap. Used only with `SEQ_TIMEOUT_EN`; valid range 1..65535.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: opcode field of the instruction register. Valid from DECODE onward.
- `br_taken` in 1: branch comparator result. Valid in EXEC.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request. Held until `mem_ready`.
- `mem_we` out 1: write request. Stores only.
- `addr_src` out 1: memory address select. 0 = PC, 1 = ALU result.
- `ir_en` out 1: instruction register load strobe.
- `pc_en` out 1: PC update strobe.
- `pc_src` out 2: next-PC select. 00 = PC+4, 01 = PC+imm, 10 = ALU (JALR).
- `reg_we` out 1: register file write strobe.
- `result_src` out 2: write-back select. 00 = ALU, 01 = memory, 10 = PC+4.
- `retire` out 1: one-cycle pulse on the final cycle of each instruction.
- `instret` out 32: retired-instruction count.
- `halted` out 1: high in TRAP.
- `trap_cause` out 2: 00 = none, 01 = illegal opcode, 10 = memory timeout.

## Operation
- State register, 3 bits, encoded as: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Encodings 7 and above go to IDLE.
- All outputs except `instret` and `trap_cause` are decoded combinationally from the state and the latched `op_q`. `instret` and `trap_cause` are registered.
- **IDLE:** all strobes low. Go to FETCH unconditionally.
- **FETCH:**
  - `mem_req`=1, `addr_src`=0.
  - On `mem_ready`: `ir_en`=1, go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE:**
  - Latch `op` into `op_q`.
  - Legal opcodes: 0x33, 0x13, 0x03, 0x23, 0x63, 0x37, 0x17, 0x6F, 0x67. A legal opcode goes to EXEC.
  - Any other opcode goes to TRAP and sets `trap_cause`=01.
- **EXEC:**
  - Load (0x03) or store (0x23): go to MEM.
  - Branch (0x63): `pc_en`=1, `pc_src`=01 if `br_taken` else 00, `retire`=1, go to FETCH.
  - All other legal opcodes: go to WB.
- **MEM:**
  - `mem_req`=1, `addr_src`=1, `mem_we`=1 for a store.
  - On `mem_ready`, store: `pc_en`=1, `pc_src`=00, `retire`=1, go to FETCH.
  - On `mem_ready`, load: go to WB.
  - Otherwise stay in MEM.
- **WB:**
  - `reg_we`=1, `pc_en`=1, `retire`=1, go to FETCH.
  - `result_src`: 01 for load; 10 for JAL/JALR; 00 otherwise.
  - `pc_src`: 01 for JAL; 10 for JALR; 00 otherwise.
- **TRAP:** all strobes low, `halted`=1. Sticky; only `rst_n` exits.
- `instret` increments by 1 on each `retire`. It wraps from 0xFFFFFFFF to 0 with no flag.

## Timing
- Reset values: state=IDLE, `op_q`=0, `instret`=0, `trap_cause`=00, wait counter=0. Every output is 0 while `rst_n` is low.
- Reset mid-instruction: `mem_req` drops asynchronously. No PC or register write occurs. Execution resumes with IDLE, then FETCH.
- Latency with `mem_ready` tied high:
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Every memory wait cycle adds 1 cycle.
- `mem_ready` is sampled only while `mem_req`=1. It is ignored in all other states.
- `mem_req` never deasserts before `mem_ready` is seen, except on reset or timeout.
- `retire` and `pc_en` are asserted in the same cycle. `ir_en` is asserted exactly once per instruction.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A 16-bit wait counter clears on entry to FETCH or MEM.
  - It increments on each cycle in FETCH or MEM with `mem_ready`=0.
  - When the counter equals `TIMEOUT_CYCLES` and `mem_ready`=0, the next state is TRAP with `trap_cause`=10.
  - If `mem_ready`=1 in that same cycle, `mem_ready` wins and normal sequencing continues.
- `SEQ_TIMEOUT_EN` undefined: no counter is built, waits are unbounded, and `trap_cause`=10 never occurs.

## Test plan
- Reset, `mem_ready`=1, `op`=0x33 → state sequence IDLE, FETCH, DECODE, EXEC, WB. `reg_we` and `retire` high in WB. `instret`=1 after 5 edges.
- Load `op`=0x03, `mem_ready` low 3 cycles in MEM → `mem_req`, `addr_src`=1 and `mem_we`=0 held through the wait. WB has `result_src`=01. Total 8 cycles.
- Branch `op`=0x63 with `br_taken`=1, then again with `br_taken`=0 → `pc_src`=01, then 00. `pc_en` and `retire` high in EXEC. No `reg_we`.
- `op`=0x7F → TRAP, `halted`=1, `trap_cause`=01. No further `mem_req` for 100 cycles. `rst_n` low restores IDLE.
- `SEQ_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=4, `mem_ready` held low in FETCH → TRAP, `trap_cause`=10. `mem_ready` rising on the threshold cycle → DECODE instead.
- Preload `instret`=0xFFFFFFFF via a forced store, retire one instruction → `instret`=0. Also assert reset mid-MEM → `mem_req` low immediately, `instret`=0.
